// File: rtl/fighter_core.sv
// fighter_core: one player's position, health and healing state for a turn-based fighting game.
module fighter_core #(
    parameter int NUM_POS     = 3,
    parameter int HP_W        = 2,
    parameter int HP_MAX      = 3,
    parameter int HEAL_WAIT   = 2,
    parameter int KICK_RANGE  = 1,
    parameter int PUNCH_RANGE = 0,
    parameter int KICK_DMG    = 1,
    parameter int PUNCH_DMG   = 2,
    localparam int PW         = $clog2(NUM_POS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            action_en_i,
    input  logic            game_over_i,
    input  logic [2:0]      my_action_i,
    input  logic [2:0]      opp_action_i,
    input  logic [PW-1:0]   opp_pos_i,
    output logic [PW-1:0]   pos_o,
    output logic [HP_W-1:0] health_o,
    output logic            ko_o,
    output logic            hit_o
);
    localparam int TOP = 2 * (NUM_POS - 1);
    logic            en_q, hit_q, strb, clash, heal, mv_r, mv_l, await_m;
    logic [PW-1:0]   pos_q, pos_d;
    logic [HP_W-1:0] health_q, health_d;
    logic [2:0]      wait_q, wait_d;
    logic [PW:0]     sum, gap;
    int              dmg;
    always_comb begin
        strb     = action_en_i && !en_q && !game_over_i && health_q != '0;
        sum      = {1'b0, pos_q} + {1'b0, opp_pos_i};
        // an out-of-range opponent index clamps the gap at zero instead of wrapping
        gap      = (int'(sum) > TOP) ? '0 : (PW+1)'(TOP - int'(sum));
        mv_r     = my_action_i[2:1] == 2'b11;
        mv_l     = my_action_i[2:1] == 2'b10;
        await_m  = my_action_i == 3'b010;
        clash    = my_action_i == 3'b000 && opp_action_i == 3'b000 && int'(gap) <= KICK_RANGE;
        dmg      = (opp_action_i == 3'b000 && int'(gap) <= KICK_RANGE && !clash && my_action_i != 3'b011) ? KICK_DMG :
                   (opp_action_i == 3'b001 && int'(gap) <= PUNCH_RANGE) ? PUNCH_DMG : 0;
        heal     = await_m && dmg == 0 && int'(wait_q) + 1 >= HEAL_WAIT;
        wait_d   = (await_m && dmg == 0 && !heal) ? wait_q + 3'd1 : 3'd0;
        pos_d    = (mv_r && gap != '0 && int'(pos_q) < NUM_POS - 1) ? pos_q + PW'(1) :
                   ((mv_l || clash) && pos_q != '0) ? pos_q - PW'(1) : pos_q;
        health_d = (dmg != 0) ? ((dmg >= int'(health_q)) ? '0 : health_q - HP_W'(dmg)) :
                   (heal && int'(health_q) < HP_MAX) ? health_q + HP_W'(1) : health_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q     <= 1'b1;
            hit_q    <= 1'b0;
            pos_q    <= '0;
            health_q <= HP_W'(HP_MAX);
            wait_q   <= 3'd0;
        end else begin
            en_q  <= action_en_i;
            hit_q <= strb && dmg != 0;
            if (strb) begin
                pos_q    <= pos_d;
                health_q <= health_d;
                wait_q   <= wait_d;
            end
        end
    end
    assign pos_o    = pos_q;
    assign health_o = health_q;
    assign ko_o     = health_q == '0;
    assign hit_o    = hit_q;
endmodule

// File: tb/tb_fighter_core.sv
// tb_fighter_core: directed scenarios for fighter_core at default and widened parameters.
module tb_fighter_core;
    localparam logic [2:0] KICK = 3'b000, PUNCH = 3'b001, AWAIT = 3'b010, JUMP = 3'b011, LEFT = 3'b100, RIGHT = 3'b110;
    logic       clk = 1'b0, reset = 1'b0, action_en = 1'b0, game_over = 1'b0;
    logic [2:0] my_act = AWAIT, opp_act = AWAIT;
    logic [1:0] opp_a = 2'd0, pos_a, health_a;
    logic [2:0] opp_b = 3'd0, pos_b;
    logic [3:0] health_b;
    logic       ko_a, hit_a, ko_b, hit_b;
    int         passed = 0, total = 0;

    always #5 clk = ~clk;

    fighter_core dut_a (
        .clk(clk), .reset(reset), .action_en_i(action_en), .game_over_i(game_over),
        .my_action_i(my_act), .opp_action_i(opp_act), .opp_pos_i(opp_a),
        .pos_o(pos_a), .health_o(health_a), .ko_o(ko_a), .hit_o(hit_a)
    );

    fighter_core #(.NUM_POS(5), .HP_W(4), .HP_MAX(12)) dut_b (
        .clk(clk), .reset(reset), .action_en_i(action_en), .game_over_i(game_over),
        .my_action_i(my_act), .opp_action_i(opp_act), .opp_pos_i(opp_b),
        .pos_o(pos_b), .health_o(health_b), .ko_o(ko_b), .hit_o(hit_b)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; action_en = 1'b0; game_over = 1'b0; my_act = AWAIT; opp_act = AWAIT;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // one round: rising action_en for one cycle; returns with hit visible
    task automatic round(input logic [2:0] m, input logic [2:0] o);
        @(negedge clk);
        my_act = m; opp_act = o; action_en = 1'b1;
        @(negedge clk);
        action_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; action_en = 1'b1; my_act = RIGHT; opp_a = 2'd0;
        repeat (2) @(negedge clk);
        total++; if (pos_a !== 2'd0) $display("FAIL reset_pos: got %0d want 0", pos_a); else passed++;
        total++; if (health_a !== 2'd3) $display("FAIL reset_health: got %0d want 3", health_a); else passed++;
        total++; if (ko_a !== 1'b0 || hit_a !== 1'b0) $display("FAIL reset_flags: ko %0b hit %0b want 0 0", ko_a, hit_a); else passed++;
        total++; if (health_b !== 4'd12) $display("FAIL reset_health_b: got %0d want 12", health_b); else passed++;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (pos_a !== 2'd0) $display("FAIL reset_release_high_en: pos %0d want 0", pos_a); else passed++;
        action_en = 1'b0;
    endtask

    task automatic test_move();
        do_reset(); opp_a = 2'd0;
        round(RIGHT, AWAIT);
        total++; if (pos_a !== 2'd1) $display("FAIL right1: pos %0d want 1", pos_a); else passed++;
        round(RIGHT, AWAIT);
        total++; if (pos_a !== 2'd2) $display("FAIL right2: pos %0d want 2", pos_a); else passed++;
        round(RIGHT, AWAIT);
        total++; if (pos_a !== 2'd2) $display("FAIL right_sat: pos %0d want 2", pos_a); else passed++;
        opp_a = 2'd2;
        round(RIGHT, AWAIT);
        total++; if (pos_a !== 2'd2) $display("FAIL right_gap0: pos %0d want 2", pos_a); else passed++;
        round(LEFT, AWAIT);
        total++; if (pos_a !== 2'd1) $display("FAIL left1: pos %0d want 1", pos_a); else passed++;
        opp_a = 2'd3;
        round(RIGHT, AWAIT);
        total++; if (pos_a !== 2'd1) $display("FAIL right_gap_clamped: pos %0d want 1", pos_a); else passed++;
        opp_a = 2'd0;
        round(LEFT, AWAIT);
        round(LEFT, AWAIT);
        total++; if (pos_a !== 2'd0) $display("FAIL left_sat: pos %0d want 0", pos_a); else passed++;
    endtask

    task automatic test_kick();
        do_reset(); opp_a = 2'd0;
        round(RIGHT, AWAIT); round(RIGHT, AWAIT);
        opp_a = 2'd1;
        round(PUNCH, KICK);
        total++; if (health_a !== 2'd2) $display("FAIL kick_dmg: health %0d want 2", health_a); else passed++;
        total++; if (hit_a !== 1'b1) $display("FAIL kick_hit: hit %0b want 1", hit_a); else passed++;
        @(negedge clk);
        total++; if (hit_a !== 1'b0) $display("FAIL kick_hit_pulse: hit %0b want 0", hit_a); else passed++;
        round(AWAIT, PUNCH);
        total++; if (health_a !== 2'd2 || hit_a !== 1'b0) $display("FAIL punch_out_of_range: health %0d hit %0b want 2 0", health_a, hit_a); else passed++;
        round(JUMP, KICK);
        total++; if (health_a !== 2'd2 || hit_a !== 1'b0) $display("FAIL jump_void: health %0d hit %0b want 2 0", health_a, hit_a); else passed++;
        opp_a = 2'd0;
        round(PUNCH, KICK);
        total++; if (health_a !== 2'd2) $display("FAIL kick_out_of_range: health %0d want 2", health_a); else passed++;
        do_reset(); opp_a = 2'd0;
        round(RIGHT, AWAIT); round(RIGHT, AWAIT);
        opp_a = 2'd1;
        round(JUMP, KICK);
        total++; if (health_a !== 2'd3 || hit_a !== 1'b0) $display("FAIL jump_full: health %0d hit %0b want 3 0", health_a, hit_a); else passed++;
    endtask

    task automatic test_ko();
        do_reset(); opp_a = 2'd0;
        round(RIGHT, AWAIT); round(RIGHT, AWAIT);
        opp_a = 2'd2;
        round(PUNCH, KICK); round(PUNCH, KICK);
        total++; if (health_a !== 2'd1) $display("FAIL ko_setup: health %0d want 1", health_a); else passed++;
        round(PUNCH, PUNCH);
        total++; if (health_a !== 2'd0 || ko_a !== 1'b1) $display("FAIL ko_sat: health %0d ko %0b want 0 1", health_a, ko_a); else passed++;
        total++; if (hit_a !== 1'b1) $display("FAIL ko_hit: hit %0b want 1", hit_a); else passed++;
        round(LEFT, KICK);
        total++; if (pos_a !== 2'd2 || health_a !== 2'd0 || hit_a !== 1'b0) $display("FAIL ko_frozen: pos %0d health %0d hit %0b want 2 0 0", pos_a, health_a, hit_a); else passed++;
        do_reset();
        total++; if (ko_a !== 1'b0 || health_a !== 2'd3) $display("FAIL ko_reset: ko %0b health %0d want 0 3", ko_a, health_a); else passed++;
    endtask

    task automatic test_heal();
        do_reset(); opp_a = 2'd0;
        round(RIGHT, AWAIT); round(RIGHT, AWAIT);
        opp_a = 2'd1;
        round(PUNCH, KICK);
        round(AWAIT, AWAIT);
        total++; if (health_a !== 2'd2) $display("FAIL heal_one_await: health %0d want 2", health_a); else passed++;
        round(AWAIT, AWAIT);
        total++; if (health_a !== 2'd3) $display("FAIL heal: health %0d want 3", health_a); else passed++;
        round(AWAIT, AWAIT); round(AWAIT, AWAIT);
        total++; if (health_a !== 2'd3) $display("FAIL heal_ceiling: health %0d want 3", health_a); else passed++;
        round(PUNCH, KICK);
        round(AWAIT, AWAIT); round(JUMP, AWAIT); round(AWAIT, AWAIT);
        total++; if (health_a !== 2'd2) $display("FAIL heal_cleared_by_jump: health %0d want 2", health_a); else passed++;
        round(AWAIT, AWAIT);
        total++; if (health_a !== 2'd3) $display("FAIL heal_after_clear: health %0d want 3", health_a); else passed++;
    endtask

    task automatic test_heal_interrupt();
        round(PUNCH, KICK);
        round(AWAIT, AWAIT);
        round(AWAIT, KICK);
        total++; if (health_a !== 2'd1 || hit_a !== 1'b1) $display("FAIL dmg_wins: health %0d hit %0b want 1 1", health_a, hit_a); else passed++;
        round(AWAIT, AWAIT);
        total++; if (health_a !== 2'd1) $display("FAIL wait_cleared_by_dmg: health %0d want 1", health_a); else passed++;
        round(AWAIT, AWAIT);
        total++; if (health_a !== 2'd2) $display("FAIL heal_after_dmg: health %0d want 2", health_a); else passed++;
    endtask

    task automatic test_game_over();
        do_reset(); opp_a = 2'd0; game_over = 1'b1;
        round(RIGHT, AWAIT);
        total++; if (pos_a !== 2'd0) $display("FAIL game_over_freeze: pos %0d want 0", pos_a); else passed++;
        @(negedge clk); action_en = 1'b1;
        @(negedge clk); game_over = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (pos_a !== 2'd0) $display("FAIL game_over_edge_lost: pos %0d want 0", pos_a); else passed++;
        action_en = 1'b0;
        round(RIGHT, AWAIT);
        total++; if (pos_a !== 2'd1) $display("FAIL after_game_over: pos %0d want 1", pos_a); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset(); opp_a = 2'd0;
        round(RIGHT, AWAIT); round(RIGHT, AWAIT); round(LEFT, AWAIT);
        total++; if (pos_a !== 2'd1) $display("FAIL toggle_rounds: pos %0d want 1", pos_a); else passed++;
    endtask

    task automatic test_wide();
        do_reset(); opp_b = 3'd0;
        repeat (4) round(RIGHT, AWAIT);
        total++; if (pos_b !== 3'd4) $display("FAIL wide_pos: pos %0d want 4", pos_b); else passed++;
        opp_b = 3'd3;
        round(KICK, KICK);
        total++; if (health_b !== 4'd12 || hit_b !== 1'b0) $display("FAIL clash_health: health %0d hit %0b want 12 0", health_b, hit_b); else passed++;
        total++; if (pos_b !== 3'd3) $display("FAIL clash_pos: pos %0d want 3", pos_b); else passed++;
        @(negedge clk); my_act = LEFT; action_en = 1'b1;
        repeat (10) @(negedge clk);
        action_en = 1'b0;
        total++; if (pos_b !== 3'd2) $display("FAIL held_en_one_round: pos %0d want 2", pos_b); else passed++;
        round(AWAIT, KICK);
        total++; if (health_b !== 4'd12) $display("FAIL wide_kick_out_of_range: health %0d want 12", health_b); else passed++;
    endtask

    initial begin
        test_reset();
        test_move();
        test_kick();
        test_ko();
        test_heal();
        test_heal_interrupt();
        test_game_over();
        test_back_to_back();
        test_wide();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
